// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, start-bit qualification at
// mid-bit, LSB-first payload capture, configurable stop bits, and a held
// result register with valid/ack handshake plus frame-error, break and
// overrun status.
//
// Handshake: uart_rx_valid rises when a frame completes and stays high
// until a clock edge where uart_rx_ack is 1. An ack while uart_rx_valid is
// 0 is ignored. A frame completing while uart_rx_valid is still high
// replaces the held data; if that same edge carries no ack, the sticky
// uart_rx_overrun flag is set.
module uart_rx #(
  parameter int BIT_RATE     = 115_200,
  parameter int CLK_HZ       = 12_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  input  logic                    uart_rx_ack,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_break,
  output logic                    uart_rx_overrun
);

  // Bit timing uses integer nanosecond periods so that the receiver
  // counts exactly like the matching transmitter (104 clocks at defaults).
  localparam int BIT_P_NS = 1_000_000_000 / BIT_RATE;
  localparam int CLK_P_NS = 1_000_000_000 / CLK_HZ;
  localparam int CPB      = BIT_P_NS / CLK_P_NS;
  localparam int HALF     = CPB / 2;
  localparam int CW       = 1 + $clog2(CPB);
  localparam int BW       = $clog2(PAYLOAD_BITS + 1);
  localparam int SW       = $clog2(STOP_BITS + 1);

  localparam logic [CW-1:0] HALF_M1   = CW'(HALF - 1);
  localparam logic [CW-1:0] CPB_M1    = CW'(CPB - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(PAYLOAD_BITS - 1);
  localparam logic [SW-1:0] LAST_STOP = SW'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RECV  = 2'd2,
    STOP  = 2'd3
  } fsm_state_t;

  // Synchronizer flops; idle line level is 1 so both reset high.
  logic rx_meta_q;
  logic rxs_q;

  // Receive datapath and control state.
  fsm_state_t               state_q,    state_d;
  logic [CW-1:0]            cnt_q,      cnt_d;
  logic [BW-1:0]            bit_cnt_q,  bit_cnt_d;
  logic [SW-1:0]            stop_cnt_q, stop_cnt_d;
  logic [PAYLOAD_BITS-1:0]  shift_q,    shift_d;
  logic                     ferr_q,     ferr_d;
  logic                     done_q,     done_d;

  // Held result registers.
  logic                     valid_q,    valid_d;
  logic [PAYLOAD_BITS-1:0]  data_q,     data_d;
  logic                     frame_err_q, frame_err_d;
  logic                     break_q,    break_d;
  logic                     overrun_q,  overrun_d;

  logic accept_ack;
  assign accept_ack = valid_q & uart_rx_ack;

  // Two-flop synchronizer for the asynchronous receive pin.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= uart_rxd;
      rxs_q     <= rx_meta_q;
    end
  end

  // Next-state logic for the receive FSM and its counters/shift register.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    ferr_d     = ferr_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d      = '0;
        bit_cnt_d  = '0;
        stop_cnt_d = '0;
        if (uart_rx_en && !rxs_q) begin
          state_d = START;
        end
      end

      START: begin
        if (!uart_rx_en) begin
          state_d = IDLE;
        end else if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          // A line that is high again at mid start bit was a glitch.
          state_d = rxs_q ? IDLE : RECV;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RECV: begin
        if (!uart_rx_en) begin
          state_d = IDLE;
        end else if (cnt_q == CPB_M1) begin
          cnt_d = '0;
          // LSB arrives first: new bit enters at the MSB and shifts right.
          shift_d = shift_q >> 1;
          shift_d[PAYLOAD_BITS-1] = rxs_q;
          if (bit_cnt_q == LAST_BIT) begin
            state_d    = STOP;
            stop_cnt_d = '0;
            ferr_d     = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      STOP: begin
        if (!uart_rx_en) begin
          state_d = IDLE;
        end else if (cnt_q == CPB_M1) begin
          cnt_d = '0;
          if (!rxs_q) begin
            ferr_d = 1'b1;
          end
          if (stop_cnt_q == LAST_STOP) begin
            // Leave at mid stop bit so the next start edge is caught.
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            stop_cnt_d = stop_cnt_q + SW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Next-state logic for the held result and status registers.
  always_comb begin
    valid_d     = valid_q;
    data_d      = data_q;
    frame_err_d = frame_err_q;
    break_d     = break_q;
    overrun_d   = overrun_q;

    if (done_q) begin
      data_d      = shift_q;
      valid_d     = 1'b1;
      frame_err_d = ferr_q;
      break_d     = ferr_q && (shift_q == '0);
      if (valid_q && !uart_rx_ack) begin
        overrun_d = 1'b1;
      end else if (accept_ack) begin
        overrun_d = 1'b0;
      end
    end else if (accept_ack) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // State registers for the FSM, datapath and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= '0;
      shift_q     <= '0;
      ferr_q      <= 1'b0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      frame_err_q <= 1'b0;
      break_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      shift_q     <= shift_d;
      ferr_q      <= ferr_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      frame_err_q <= frame_err_d;
      break_q     <= break_d;
      overrun_q   <= overrun_d;
    end
  end

  assign uart_rx_valid     = valid_q;
  assign uart_rx_data      = data_q;
  assign uart_rx_frame_err = frame_err_q;
  assign uart_rx_break     = break_q;
  assign uart_rx_overrun   = overrun_q;

endmodule
